// File: rtl/matmul_pkg.sv
// Shared state codes and sizing helpers for the matrix-multiply sequencer.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_CALC   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam int MAC_LAT_MIN = 1;

    // Never returns 0, so single-entry buffers still get a 1-bit address.
    function automatic int safe_clog2(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_wr_delay.sv
// Valid+data shift register with synchronous flush; models the MAC pipeline
// latency between a final-k beat and its result write.
module matmul_wr_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o
);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][WIDTH-1:0] dat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else if (flush_i) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= in_valid_i;
            dat_q[0] <= in_data_i;
            for (int n = 1; n < DEPTH; n++) begin
                vld_q[n] <= vld_q[n-1];
                dat_q[n] <= dat_q[n-1];
            end
        end
    end

    assign out_valid_o = vld_q[DEPTH-1];
    assign out_data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for C = A*B: streams A then B into operand buffers, issues one MAC
// beat per cycle, and writes each C element after the MAC pipeline latency.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int  M       = 2,
    parameter int  K       = 2,
    parameter int  P       = 2,
    parameter int  MAC_LAT = 2,
    localparam int AW_A    = safe_clog2(M * K),
    localparam int AW_B    = safe_clog2(K * P),
    localparam int AW_C    = safe_clog2(M * P),
    localparam int LW      = (AW_A > AW_B) ? AW_A : AW_B
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            ld_we,
    output logic            ld_sel,
    output logic [LW-1:0]   ld_addr,
    output logic            mac_en,
    output logic            mac_clr,
    output logic [AW_A-1:0] a_addr,
    output logic [AW_B-1:0] b_addr,
    output logic            res_we,
    output logic [AW_C-1:0] res_addr,
    output logic            busy,
    output logic            done,
    output logic [2:0]      state
);

    localparam int DLY = (MAC_LAT < MAC_LAT_MIN) ? MAC_LAT_MIN : MAC_LAT;
    localparam int IW  = safe_clog2(M);
    localparam int JW  = safe_clog2(P);
    localparam int KW  = safe_clog2(K);
    localparam int DW  = safe_clog2(DLY);

    localparam logic [LW-1:0] A_LAST = LW'(M * K - 1);
    localparam logic [LW-1:0] B_LAST = LW'(K * P - 1);
    localparam logic [IW-1:0] I_LAST = IW'(M - 1);
    localparam logic [JW-1:0] J_LAST = JW'(P - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DLY - 1);

    state_e          state_q;
    logic [LW-1:0]   ld_q;
    logic [IW-1:0]   i_q;
    logic [JW-1:0]   j_q;
    logic [KW-1:0]   k_q;
    logic [DW-1:0]   dr_q;
    logic            flush;
    logic            push;
    logic [AW_C-1:0] push_addr;

    // abort outranks every transition, including the last-beat ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ld_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            dr_q    <= '0;
        end else if (abort && state_q != ST_IDLE) begin
            state_q <= ST_IDLE;
            ld_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            dr_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD_A;
                        ld_q    <= '0;
                    end
                end
                ST_LOAD_A: begin
                    if (in_valid) begin
                        if (ld_q == A_LAST) begin
                            state_q <= ST_LOAD_B;
                            ld_q    <= '0;
                        end else begin
                            ld_q <= ld_q + LW'(1);
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (in_valid) begin
                        if (ld_q == B_LAST) begin
                            state_q <= ST_CALC;
                            ld_q    <= '0;
                            i_q     <= '0;
                            j_q     <= '0;
                            k_q     <= '0;
                        end else begin
                            ld_q <= ld_q + LW'(1);
                        end
                    end
                end
                ST_CALC: begin
                    if (k_q == K_LAST) begin
                        k_q <= '0;
                        if (j_q == J_LAST) begin
                            j_q <= '0;
                            if (i_q == I_LAST) begin
                                i_q     <= '0;
                                state_q <= ST_DRAIN;
                                dr_q    <= '0;
                            end else begin
                                i_q <= i_q + IW'(1);
                            end
                        end else begin
                            j_q <= j_q + JW'(1);
                        end
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (dr_q == D_LAST) begin
                        state_q <= ST_DONE;
                        dr_q    <= '0;
                    end else begin
                        dr_q <= dr_q + DW'(1);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    assign ld_we    = in_valid && in_ready;
    assign ld_sel   = (state_q == ST_LOAD_B);
    assign ld_addr  = ld_q;
    assign mac_en   = (state_q == ST_CALC);
    assign mac_clr  = mac_en && (k_q == '0);
    assign a_addr   = AW_A'(i_q * K + k_q);
    assign b_addr   = AW_B'(k_q * P + j_q);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign state    = state_q;

    // Idle stages carry zero so res_addr reads 0 whenever res_we is low.
    assign flush     = abort && (state_q != ST_IDLE);
    assign push      = mac_en && (k_q == K_LAST);
    assign push_addr = push ? AW_C'(i_q * P + j_q) : '0;

    matmul_wr_delay #(
        .DEPTH(DLY),
        .WIDTH(AW_C)
    ) u_wr_delay (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .in_valid_i (push),
        .in_data_i  (push_addr),
        .out_valid_o(res_we),
        .out_data_o (res_addr)
    );

endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Parametrised sequencer for the matrix-multiply engine, computing C[M×P] = A[M×K] · B[K×P]. It streams A then B, element by element, into the operand buffers over a valid/ready input. It then issues one MAC beat per cycle with explicit operand addresses and writes each result element after a configurable MAC pipeline latency. It sits between the host-side stream and the operand buffers, MAC datapath and result buffer, and replaces the fixed-step load/calc controller with dimension-aware counters, flow control, abort and drain.

## Interface
- M, 2, rows of A and C (≥1)
- K, 2, inner dimension (≥1)
- P, 2, columns of B and C (≥1)
- MAC_LAT, 2, cycles from mac_en beat to valid MAC output (≥1)
- AW_A / AW_B / AW_C, derived, max(1, clog2(M*K)) / max(1, clog2(K*P)) / max(1, clog2(M*P))

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a job; sampled only in IDLE
- abort  in  1  synchronous cancel; any non-IDLE state goes to IDLE next cycle
- in_valid  in  1  input element present
- in_ready  out  1  high in LOAD_A/LOAD_B
- ld_we  out  1  in_valid & in_ready
- ld_sel  out  1  0 = A buffer, 1 = B buffer
- ld_addr  out  max(AW_A,AW_B)  row-major write address
- mac_en  out  1  MAC beat
- mac_clr  out  1  mac_en & (k==0): accumulator restarts
- a_addr  out  AW_A  i*K+k
- b_addr  out  AW_B  k*P+j
- res_we  out  1  result write strobe
- res_addr  out  AW_C  i*P+j of the written result
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse in DONE
- state  out  3  current state code

## Operation
- States: IDLE=0, LOAD_A=1, LOAD_B=2, CALC=3, DRAIN=4, DONE=5. Codes 6–7 go to IDLE.
- IDLE: start=1 → LOAD_A; load counter cleared.
- LOAD_A: each accepted beat writes A[ld_addr] and increments ld_addr. The accept at ld_addr==M*K-1 → LOAD_B with ld_addr=0. in_valid low stalls with no state change.
- LOAD_B: same rule with limit K*P. The last accept → CALC with i=j=k=0.
- CALC: mac_en=1 every cycle with no stall. Loops nest k innermost, then j, then i. Each counter wraps to 0 when the next outer counter increments. The beat at i=M-1, j=P-1, k=K-1 → DRAIN.
- Result path: the beat with k==K-1 pushes {1, i*P+j} into a MAC_LAT-deep delay line. Its output drives res_we/res_addr, so exactly M*P writes occur in ascending res_addr order.
- DRAIN: lasts exactly MAC_LAT cycles → DONE.
- DONE: done=1 for one cycle → IDLE. busy drops in the same cycle state returns to IDLE.
- start outside IDLE is ignored. abort has priority over every other transition, including the last-beat transitions. abort also flushes the delay line (no res_we after abort) and suppresses done. abort in IDLE has no effect.
- K==1: mac_clr is high on every beat. M=K=P=1 is legal.

## Timing
- Reset values: state=IDLE, all counters and the delay line 0. All outputs 0, including in_ready, busy and done.
- Registered state. ld_we, mac_en, mac_clr and the addresses are combinational from state and counters, valid in the cycle they address.
- With start sampled at cycle t0 and in_valid held high: LOAD_A spans t0+1..t0+MK.
  - CALC begins at t0+1+MK+KP.
  - done is at t0+1+MK+KP+MPK+MAC_LAT.
  - The last res_we falls in the final DRAIN cycle.
- Each low in_valid cycle during load adds exactly one cycle.
- rst mid-job returns to reset values immediately. There is no res_we or done afterwards.

## Structure
- Package matmul_pkg holds: the state enum/codes, a safe-clog2 function (returns ≥1), and the MAC_LAT lower bound constant.
- Sub-module matmul_wr_delay is a parametrised (depth, payload width) valid+data shift register with synchronous flush. It implements the result delay line.
- All counters and the FSM live in matmul_seq_ctrl.

## Test plan
- M=K=P=2, MAC_LAT=2, in_valid held high, start at t0:
  - ld_addr runs 0..3 with ld_sel=0, then 0..3 with ld_sel=1.
  - 8 mac_en beats; mac_clr on beats 0,2,4,6.
  - a_addr/b_addr sequence is (0,0),(1,2),(0,1),(1,3),(2,0),(3,2),(2,1),(3,3).
  - res_addr sequence is 0,1,2,3.
  - done at t0+19.
- Same job with in_valid low for 3 scattered cycles → done at t0+22; addresses unchanged.
- M=K=P=1, MAC_LAT=1 → one A load, one B load, one beat with mac_clr=1, res_we at res_addr 0, done at t0+5.
- M=2,K=3,P=2: abort asserted on the 5th CALC beat → IDLE next cycle; no further mac_en, res_we or done; a new start then completes normally.
- start pulsed during LOAD_B and CALC → ignored; the job completes with a single done.
- rst asserted mid-LOAD_A → all outputs 0 immediately, state=0; a following job starts at ld_addr 0.
